// File: rtl/xcorr_ifft_bfp_peak.sv
// Block-floating-point de-normaliser and correlation peak tracker for
// correlator IFFT output frames. Each sample is shifted left by the frame
// exponent and clipped symmetrically. The |I|+|Q| peak of every frame, plus
// its index and exponent, is reported at frame end with a threshold flag and
// error strobes.
module xcorr_ifft_bfp_peak #(
    parameter int DW    = 16,
    parameter int EXPW  = 5,
    parameter int OW    = 24,
    parameter int NLOG2 = 10,
    parameter int MAXSH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ival,
    input  logic signed [DW-1:0]    idata_i,
    input  logic signed [DW-1:0]    idata_q,
    input  logic [EXPW-1:0]         iexp,
    input  logic                    ieop,
    input  logic                    scale_en,
    input  logic [OW:0]             thr,
    output logic                    oval,
    output logic signed [OW-1:0]    odata_i,
    output logic signed [OW-1:0]    odata_q,
    output logic                    oeop,
    output logic                    pk_valid,
    output logic [OW:0]             pk_mag,
    output logic [NLOG2-1:0]        pk_idx,
    output logic [EXPW-1:0]         pk_exp,
    output logic                    pk_det,
    output logic                    len_err,
    output logic                    exp_err
);
    localparam int XW  = OW + MAXSH;
    localparam int SHW = $clog2(MAXSH + 1);
    localparam logic signed [XW-1:0] SAT_POS = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [XW-1:0] SAT_NEG = -SAT_POS;

    typedef enum logic {IDLE, RUN} state_t;

    // Clip to the symmetric range; the most negative code is never produced.
    function automatic logic signed [OW-1:0] saturate(input logic signed [XW-1:0] v);
        if (v > SAT_POS)      return SAT_POS[OW-1:0];
        else if (v < SAT_NEG) return SAT_NEG[OW-1:0];
        else                  return v[OW-1:0];
    endfunction

    function automatic logic [OW:0] mag_abs(input logic signed [OW-1:0] v);
        logic signed [OW:0] e;
        e = {v[OW-1], v};
        return e[OW] ? -e : e;
    endfunction

    state_t               state, state_nxt;
    logic [NLOG2-1:0]     idx;
    logic [EXPW-1:0]      lat_exp, cur_exp;
    logic [SHW-1:0]       lat_sh, cur_sh, exp_sh;
    logic                 first, last_idx, frame_end;

    // Stage 1: registered sample plus per-frame context travelling with it.
    logic                 s1_val, s1_eop, s1_first, s1_len;
    logic signed [DW-1:0] s1_i, s1_q;
    logic [NLOG2-1:0]     s1_idx;
    logic [SHW-1:0]       s1_sh;
    logic [EXPW-1:0]      s1_exp;

    // Stage 2 side-band (data lives on the output ports).
    logic [OW:0]          s2_mag;
    logic [NLOG2-1:0]     s2_idx;
    logic [EXPW-1:0]      s2_exp;
    logic                 s2_first, s2_len;

    logic signed [XW-1:0] ext_i, ext_q;
    logic signed [OW-1:0] sat_i, sat_q;

    logic [OW:0]          run_mag, fin_mag;
    logic [NLOG2-1:0]     run_idx, fin_idx;
    logic                 take;

    // Frame control: detect first/last sample and pick the shift for this sample.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_nxt = state;
        first     = (state == IDLE);
        last_idx  = &idx;
        frame_end = ieop || last_idx;
        exp_sh    = (iexp > EXPW'(MAXSH)) ? SHW'(MAXSH) : iexp[SHW-1:0];
        cur_sh    = lat_sh;
        cur_exp   = lat_exp;
        if (first) begin
            cur_sh  = scale_en ? exp_sh : '0;
            cur_exp = iexp;
        end
        if (ival) state_nxt = frame_end ? IDLE : RUN;
    end

    // Frame state, sample index, latched exponent/shift and exponent-change strobe.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from pre-edge values.
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            lat_exp <= '0;
            lat_sh  <= '0;
            exp_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            exp_err <= ival && !first && (iexp != lat_exp);
            if (ival) begin
                idx <= frame_end ? '0 : idx + NLOG2'(1);
                if (first) begin
                    lat_exp <= iexp;
                    lat_sh  <= cur_sh;
                end
            end
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_val   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_first <= 1'b0;
            s1_len   <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_idx   <= '0;
            s1_sh    <= '0;
            s1_exp   <= '0;
        end else begin
            s1_val <= ival;
            s1_eop <= ival && frame_end;
            if (ival) begin
                s1_first <= first;
                s1_len   <= !(ieop && last_idx);
                s1_i     <= idata_i;
                s1_q     <= idata_q;
                s1_idx   <= idx;
                s1_sh    <= cur_sh;
                s1_exp   <= cur_exp;
            end
        end
    end

    // Stage 2 arithmetic: sign-extend, shift, clip.
    always_comb begin
        ext_i = {{(XW-DW){s1_i[DW-1]}}, s1_i} <<< s1_sh;
        ext_q = {{(XW-DW){s1_q[DW-1]}}, s1_q} <<< s1_sh;
        sat_i = saturate(ext_i);
        sat_q = saturate(ext_q);
    end

    // Stage 2 register: scaled output sample and its magnitude.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oval     <= 1'b0;
            oeop     <= 1'b0;
            odata_i  <= '0;
            odata_q  <= '0;
            s2_mag   <= '0;
            s2_idx   <= '0;
            s2_exp   <= '0;
            s2_first <= 1'b0;
            s2_len   <= 1'b0;
        end else begin
            oval <= s1_val;
            oeop <= s1_eop;
            if (s1_val) begin
                odata_i  <= sat_i;
                odata_q  <= sat_q;
                s2_mag   <= mag_abs(sat_i) + mag_abs(sat_q);
                s2_idx   <= s1_idx;
                s2_exp   <= s1_exp;
                s2_first <= s1_first;
                s2_len   <= s1_len;
            end
        end
    end

    // Peak candidate including the current stage-2 sample; strict > keeps the first maximum.
    always_comb begin
        take    = s2_first || (s2_mag > run_mag);
        fin_mag = take ? s2_mag : run_mag;
        fin_idx = take ? s2_idx : run_idx;
    end

    // Running peak and frame-end result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_mag  <= '0;
            run_idx  <= '0;
            pk_valid <= 1'b0;
            len_err  <= 1'b0;
            pk_mag   <= '0;
            pk_idx   <= '0;
            pk_exp   <= '0;
            pk_det   <= 1'b0;
        end else begin
            pk_valid <= oval && oeop;
            len_err  <= oval && oeop && s2_len;
            if (oval) begin
                run_mag <= fin_mag;
                run_idx <= fin_idx;
            end
            if (oval && oeop) begin
                pk_mag <= fin_mag;
                pk_idx <= fin_idx;
                pk_exp <= s2_exp;
                pk_det <= fin_mag > thr;
            end
        end
    end

endmodule

// File: tb/tb_xcorr_ifft_bfp_peak.sv
// Self-checking bench for xcorr_ifft_bfp_peak: directed frames from the test
// plan plus random frames, compared cycle by cycle against a frame-level model.
module tb_xcorr_ifft_bfp_peak;
    localparam int DW = 16, EXPW = 5, OW = 24, NLOG2 = 10, MAXSH = 8;
    localparam int N = 1 << NLOG2;
    localparam longint SATV = (longint'(1) << (OW - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ival = 1'b0, ieop = 1'b0, scale_en = 1'b0;
    logic signed [DW-1:0] idata_i = '0, idata_q = '0;
    logic [EXPW-1:0]      iexp = '0;
    logic [OW:0]          thr = '0;
    logic                 oval, oeop, pk_valid, pk_det, len_err, exp_err;
    logic signed [OW-1:0] odata_i, odata_q;
    logic [OW:0]          pk_mag;
    logic [NLOG2-1:0]     pk_idx;
    logic [EXPW-1:0]      pk_exp;

    xcorr_ifft_bfp_peak #(.DW(DW), .EXPW(EXPW), .OW(OW), .NLOG2(NLOG2), .MAXSH(MAXSH)) dut (
        .clk(clk), .rst(rst), .ival(ival), .idata_i(idata_i), .idata_q(idata_q),
        .iexp(iexp), .ieop(ieop), .scale_en(scale_en), .thr(thr),
        .oval(oval), .odata_i(odata_i), .odata_q(odata_q), .oeop(oeop),
        .pk_valid(pk_valid), .pk_mag(pk_mag), .pk_idx(pk_idx), .pk_exp(pk_exp),
        .pk_det(pk_det), .len_err(len_err), .exp_err(exp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { longint i; longint q; bit eop; } out_t;
    typedef struct { longint mag; int idx; int e; bit len; } pk_t;

    out_t   exp_o[int];     // keyed by the cycle the output must appear
    pk_t    exp_pk[int];
    bit     exp_ee[int];
    bit     m_run = 0;
    int     m_idx = 0, m_exp = 0, m_sh = 0;
    longint fq[$];          // magnitudes of the frame in progress
    longint h_mag = 0;
    int     h_idx = 0, h_exp = 0;
    bit     h_det = 0;
    logic [OW:0] thr_last = '0;

    function automatic longint scale(input int x, input int sh);
        longint v;
        v = longint'(x) * (longint'(1) << sh);
        if (v > SATV)  v = SATV;
        if (v < -SATV) v = -SATV;
        return v;
    endfunction

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rnd_s();
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        return int'(r);
    endfunction

    task automatic model_step(input int i, input int q, input int e, input bit eop, input bit sen);
        bit     last;
        longint si, sq;
        int     best;
        if (!m_run) begin
            m_exp = e;
            m_sh  = sen ? ((e > MAXSH) ? MAXSH : e) : 0;
            fq.delete();
        end else if (e != m_exp) begin
            exp_ee[cyc + 1] = 1'b1;
        end
        si = scale(i, m_sh);
        sq = scale(q, m_sh);
        fq.push_back(absl(si) + absl(sq));
        last = eop || (m_idx == N - 1);
        exp_o[cyc + 2] = '{si, sq, last};
        if (last) begin
            best = 0;
            for (int k = 1; k < fq.size(); k++)
                if (fq[k] > fq[best]) best = k;
            exp_pk[cyc + 3] = '{fq[best], best, m_exp, !(eop && fq.size() == N)};
            m_run = 0;
            m_idx = 0;
        end else begin
            m_run = 1;
            m_idx++;
        end
    endtask

    // One clock of stimulus; junk on data/eop when not valid.
    task automatic send(input bit v, input int i, input int q, input int e, input bit eop, input bit sen);
        @(posedge clk);
        #1;
        ival     = v;
        idata_i  = v ? DW'(i) : DW'($urandom);
        idata_q  = v ? DW'(q) : DW'($urandom);
        iexp     = EXPW'(e);
        ieop     = v ? eop : 1'($urandom);
        scale_en = sen;
        if (v) model_step(i, q, e, eop, sen);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ival = 1'b0;
        m_run = 0; m_idx = 0; fq.delete();
        exp_o.delete(); exp_pk.delete(); exp_ee.delete();
        h_mag = 0; h_idx = 0; h_exp = 0; h_det = 0;
        #1;
        check("rst_oval", oval, 0);
        check("rst_odata_i", odata_i, 0);
        check("rst_odata_q", odata_q, 0);
        check("rst_oeop", oeop, 0);
        check("rst_pk_valid", pk_valid, 0);
        check("rst_pk_mag", pk_mag, 0);
        check("rst_pk_idx", pk_idx, 0);
        check("rst_pk_exp", pk_exp, 0);
        check("rst_pk_det", pk_det, 0);
        check("rst_len_err", len_err, 0);
        check("rst_exp_err", exp_err, 0);
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Cycle-by-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        out_t o;
        pk_t  p;
        bit   ho, hp, he;
        if (!rst) begin
            ho = exp_o.exists(cyc);
            hp = exp_pk.exists(cyc);
            he = exp_ee.exists(cyc);
            check("oval", oval, ho);
            if (ho) begin
                o = exp_o[cyc];
                check("odata_i", odata_i, o.i);
                check("odata_q", odata_q, o.q);
                check("oeop", oeop, o.eop);
                exp_o.delete(cyc);
            end
            check("pk_valid", pk_valid, hp);
            if (hp) begin
                p = exp_pk[cyc];
                h_mag = p.mag;
                h_idx = p.idx;
                h_exp = p.e;
                h_det = p.mag > longint'(thr_last);
                check("len_err", len_err, p.len);
                exp_pk.delete(cyc);
            end else begin
                check("len_err_idle", len_err, 0);
            end
            check("pk_mag", pk_mag, h_mag);
            check("pk_idx", pk_idx, h_idx);
            check("pk_exp", pk_exp, h_exp);
            check("pk_det", pk_det, h_det);
            check("exp_err", exp_err, he);
            if (he) exp_ee.delete(cyc);
        end
        thr_last = thr;
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset(2);

        // Nominal frame: background 100/-50, peak 1000/0 at index 77, shift 3.
        thr = 25'd1000;
        for (int k = 0; k < N; k++) begin
            if (k == 77) send(1'b1, 1000, 0, 3, k == N - 1, 1'b1);
            else         send(1'b1, 100, -50, 3, k == N - 1, 1'b1);
        end
        idle(5);
        check("tp1_pk_mag", pk_mag, 8000);
        check("tp1_pk_idx", pk_idx, 77);
        check("tp1_pk_exp", pk_exp, 3);
        check("tp1_pk_det", pk_det, 1);

        // Clamped exponent 20 -> shift 8. 32767<<8 stays below the rail;
        // -32768<<8 clips to -(2^23-1).
        for (int k = 0; k < 4; k++) send(1'b1, 32767, -32768, 20, k == 3, 1'b1);
        idle(5);
        check("sat_pk_mag", pk_mag, 8388352 + 8388607);
        check("sat_pk_exp", pk_exp, 20);

        // Equal magnitudes at 10 and 900: first one wins; threshold just below/at.
        for (int r = 0; r < 2; r++) begin
            thr = (r == 0) ? 25'd499 : 25'd500;
            for (int k = 0; k < N; k++) begin
                if (k == 10)       send(1'b1, 500, 0, 0, k == N - 1, 1'b0);
                else if (k == 900) send(1'b1, -250, 250, 0, k == N - 1, 1'b0);
                else               send(1'b1, 1, 1, 0, k == N - 1, 1'b0);
            end
            idle(4);
            check("tie_pk_idx", pk_idx, 10);
            check("tie_pk_mag", pk_mag, 500);
            check("tie_pk_det", pk_det, (r == 0) ? 1 : 0);
        end

        // Short frame ending at index 99, then 1030 samples with ieop on the last.
        thr = 25'($urandom);
        for (int k = 0; k < 100; k++) send(1'b1, rnd_s(), rnd_s(), 4, k == 99, 1'b1);
        idle(2);
        for (int k = 0; k < 1030; k++) send(1'b1, rnd_s(), rnd_s(), 1, k == 1029, 1'b1);
        idle(5);
        check("long_tail_pk_idx_range", pk_idx < 6, 1);

        // Back-to-back frames, exponent 2 then 5, with a mid-frame exponent change.
        for (int k = 0; k < 300; k++) send(1'b1, rnd_s(), rnd_s(), 2, k == 299, 1'b1);
        for (int k = 0; k < 200; k++)
            send(1'b1, rnd_s(), rnd_s(), (k >= 50 && k < 53) ? 7 : 5, k == 199, 1'b1);
        idle(5);
        check("b2b_pk_exp", pk_exp, 5);

        // Reset at index 500 of a loud frame; the following quiet frame must not see it.
        for (int k = 0; k < 500; k++) send(1'b1, 20000, -20000, 8, 1'b0, 1'b1);
        do_reset(3);
        for (int k = 0; k < N; k++) send(1'b1, 3, 4, 0, k == N - 1, 1'b0);
        idle(5);
        check("post_rst_pk_mag", pk_mag, 7);
        check("post_rst_pk_idx", pk_idx, 0);

        // Random frames: random lengths, gaps, exponents, shifts and thresholds.
        for (int f = 0; f < 6; f++) begin
            int len, e;
            bit sen;
            len = $urandom_range(1, 1100);
            e   = $urandom_range(0, 31);
            sen = 1'($urandom_range(0, 1));
            thr = 25'($urandom);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) idle(1);
                send(1'b1, rnd_s(), rnd_s(),
                     ($urandom_range(0, 63) == 0) ? int'($urandom_range(0, 31)) : e,
                     k == len - 1, sen);
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
